// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM states
// and the store-side lane helpers.
package mem_pkg;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // Encoding 2'b11 falls into the default arm and behaves as a word access.
    function automatic logic [3:0] lane_enables(input logic [1:0] mask, input logic [1:0] lane);
        case (mask)
            MASK_BYTE: return 4'b0001 << lane;
            MASK_HALF: return 4'b0011 << lane;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate_store(input logic [1:0] mask, input logic [31:0] data);
        case (mask)
            MASK_BYTE: return {4{data[7:0]}};
            MASK_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data formatter: shifts the addressed lane down to bit 0 and applies
// sign or zero extension for byte and half accesses.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  mask_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted = rdata_i >> {lane_i, 3'b000};
        case (mask_i)
            MASK_BYTE: data_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
            MASK_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default:   data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: converts EX/MEM load/store control into a req/ack bus
// transaction, stalls upstream while it is outstanding and drives MEM/WB.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset_n,
    input  logic                      i_Stall,
    input  logic [DATA_WIDTH-1:0]     i_ALU_Result,
    input  logic [DATA_WIDTH-1:0]     i_Store_Data,
    input  logic                      i_Mem_Read,
    input  logic                      i_Mem_Write,
    input  logic [1:0]                i_Mem_Mask,
    input  logic                      i_Load_Unsigned,
    input  logic                      i_Writes_Back,
    input  logic [REG_ADDR_WIDTH-1:0] i_Write_Addr,
    output logic                      o_Mem_Req,
    output logic                      o_Mem_We,
    output logic [ADDRESS_WIDTH-1:0]  o_Mem_Addr,
    output logic [3:0]                o_Mem_Byte_En,
    output logic [DATA_WIDTH-1:0]     o_Mem_Wdata,
    input  logic                      i_Mem_Ack,
    input  logic [DATA_WIDTH-1:0]     i_Mem_Rdata,
    output logic                      o_Stall_Pipeline,
    output logic                      o_Misaligned,
    output logic [DATA_WIDTH-1:0]     o_WriteBack_Data,
    output logic                      o_Writes_Back,
    output logic [REG_ADDR_WIDTH-1:0] o_Write_Addr
);

    mem_state_e               state_q, state_d;
    logic                     req_q, req_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]               be_q, be_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rd_q, rd_d;

    logic                     any_access;
    logic                     size_misaligned;
    logic                     memop;
    logic                     is_load;
    logic [1:0]               lane;
    logic [ADDRESS_WIDTH-1:0] addr_aligned;
    logic [DATA_WIDTH-1:0]    load_data;

    assign lane         = i_ALU_Result[1:0];
    assign any_access   = i_Mem_Read | i_Mem_Write;
    assign is_load      = i_Mem_Read & ~i_Mem_Write;
    assign addr_aligned = ADDRESS_WIDTH'(i_ALU_Result & ~DATA_WIDTH'(3));

    always_comb begin
        case (i_Mem_Mask)
            MASK_BYTE: size_misaligned = 1'b0;
            MASK_HALF: size_misaligned = lane[0];
            default:   size_misaligned = (lane != 2'b00);
        endcase
    end

    assign o_Misaligned = any_access & size_misaligned;
    assign memop        = any_access & ~o_Misaligned;

    mem_load_align u_load_align (
        .rdata_i    (i_Mem_Rdata),
        .lane_i     (lane),
        .mask_i     (i_Mem_Mask),
        .unsigned_i (i_Load_Unsigned),
        .data_o     (load_data)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = i_Mem_Write;
                    addr_d  = addr_aligned;
                    be_d    = lane_enables(i_Mem_Mask, lane);
                    wdata_d = replicate_store(i_Mem_Mask, i_Store_Data);
                end
            end
            ST_BUSY: begin
                // Bus outputs hold their registered values until the ack arrives.
                if (i_Mem_Ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    rd_d    = load_data;
                end
            end
            ST_DONE: begin
                if (!i_Stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    assign o_Mem_Req     = req_q;
    assign o_Mem_We      = we_q;
    assign o_Mem_Addr    = addr_q;
    assign o_Mem_Byte_En = be_q;
    assign o_Mem_Wdata   = wdata_q;

    assign o_Stall_Pipeline = memop & (state_q != ST_DONE);

    // Combined read+write is a store; a misaligned load is squashed.
    assign o_Writes_Back    = i_Writes_Back & ~(i_Mem_Read & i_Mem_Write) & ~(i_Mem_Read & o_Misaligned);
    assign o_WriteBack_Data = (state_q == ST_DONE && is_load) ? rd_q : i_ALU_Result;
    assign o_Write_Addr     = i_Write_Addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        mrd, mwr;
    logic [1:0]  mask;
    logic        uns;
    logic        wb_in;
    logic [4:0]  wa_in;
    logic        req, we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        stall_out, mis_out;
    logic [31:0] wb_data;
    logic        wb_out;
    logic [4:0]  wa_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .i_Clk            (clk),
        .i_Reset_n        (rst_n),
        .i_Stall          (stall_in),
        .i_ALU_Result     (alu),
        .i_Store_Data     (sdata),
        .i_Mem_Read       (mrd),
        .i_Mem_Write      (mwr),
        .i_Mem_Mask       (mask),
        .i_Load_Unsigned  (uns),
        .i_Writes_Back    (wb_in),
        .i_Write_Addr     (wa_in),
        .o_Mem_Req        (req),
        .o_Mem_We         (we),
        .o_Mem_Addr       (maddr),
        .o_Mem_Byte_En    (be),
        .o_Mem_Wdata      (wdata),
        .i_Mem_Ack        (ack),
        .i_Mem_Rdata      (rdata),
        .o_Stall_Pipeline (stall_out),
        .o_Misaligned     (mis_out),
        .o_WriteBack_Data (wb_data),
        .o_Writes_Back    (wb_out),
        .o_Write_Addr     (wa_out)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                               input logic [1:0] m, input bit u);
        int unsigned off = addr % 4;
        logic [31:0] v   = rd >> (8 * off);
        if (m == 2'd0) begin
            v = v & 32'hFF;
            if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (m == 2'd1) begin
            v = v & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] m);
        int unsigned off = addr % 4;
        if (m == 2'd0) return 4'(1 << off);
        if (m == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] m);
        if (m == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (m == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // One instruction held in the stage until it completes; n_busy cycles of Req before ack,
    // then 'hold' extra DONE cycles under i_Stall.
    task automatic run_op(input string name, input bit r, input bit w, input logic [1:0] m,
                          input logic [31:0] addr, input logic [31:0] sd, input bit u,
                          input bit wbe, input logic [4:0] wa, input int n_busy,
                          input logic [31:0] rd, input int hold);
        bit          exp_mis  = (r || w) && ((m == 2'd1 && addr % 2 != 0) || (m >= 2'd2 && addr % 4 != 0));
        bit          exp_mop  = (r || w) && !exp_mis;
        bit          ld       = r && !w;
        bit          exp_wb   = wbe && !(r && w) && !(r && exp_mis);
        logic [31:0] exp_data = ld ? model_load(rd, addr, m, u) : addr;

        @(posedge clk); #1;
        mrd = r; mwr = w; mask = m; alu = addr; sdata = sd; uns = u;
        wb_in = wbe; wa_in = wa; ack = 1'b0; stall_in = 1'b0; rdata = $urandom;
        #1;
        check({name, ":misaligned"}, 32'(mis_out), 32'(exp_mis));
        check({name, ":stall0"},     32'(stall_out), 32'(exp_mop));
        check({name, ":req0"},       32'(req), 32'd0);
        check({name, ":wbdata0"},    wb_data, addr);
        check({name, ":writes_back"}, 32'(wb_out), 32'(exp_wb));
        check({name, ":write_addr"}, 32'(wa_out), 32'(wa));

        if (!exp_mop) begin
            @(posedge clk); #2;
            check({name, ":req_idle"},   32'(req), 32'd0);
            check({name, ":stall_idle"}, 32'(stall_out), 32'd0);
            return;
        end

        for (int k = 1; k <= n_busy; k++) begin
            @(posedge clk); #1;
            ack   = (k == n_busy);
            rdata = (k == n_busy) ? rd : $urandom;
            #1;
            check({name, ":req_busy"},   32'(req), 32'd1);
            check({name, ":stall_busy"}, 32'(stall_out), 32'd1);
            check({name, ":addr"},       maddr, addr & ~32'd3);
            if (k == 1) begin
                check({name, ":be"}, 32'(be), 32'(model_be(addr, m)));
                check({name, ":we"}, 32'(we), 32'(w));
                if (w) check({name, ":wdata"}, wdata, model_wdata(sd, m));
            end
        end

        @(posedge clk); #1;
        ack = 1'b0; rdata = $urandom;
        #1;
        check({name, ":req_done"},    32'(req), 32'd0);
        check({name, ":stall_done"},  32'(stall_out), 32'd0);
        check({name, ":wbdata_done"}, wb_data, exp_data);
        check({name, ":wb_done"},     32'(wb_out), 32'(exp_wb));

        for (int j = 0; j < hold; j++) begin
            stall_in = 1'b1;
            @(posedge clk); #2;
            check({name, ":req_hold"},    32'(req), 32'd0);
            check({name, ":stall_hold"},  32'(stall_out), 32'd0);
            check({name, ":wbdata_hold"}, wb_data, exp_data);
        end
        stall_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall_in = 1'b0; alu = 32'h0; sdata = 32'h0; mrd = 1'b0; mwr = 1'b0;
        mask = 2'd0; uns = 1'b0; wb_in = 1'b0; wa_in = 5'd0; ack = 1'b0; rdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset:req",   32'(req), 32'd0);
        check("reset:we",    32'(we), 32'd0);
        check("reset:addr",  maddr, 32'd0);
        check("reset:be",    32'(be), 32'd0);
        check("reset:wdata", wdata, 32'd0);
        check("reset:stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add",     0, 0, 2'd2, 32'h0000_1234, 32'h0,         0, 1, 5'd3, 1, 32'h0,         0);
        run_op("lw",      1, 0, 2'd2, 32'h0000_0100, 32'h0,         0, 1, 5'd4, 3, 32'hDEAD_BEEF, 0);
        run_op("lb",      1, 0, 2'd0, 32'h0000_0203, 32'h0,         0, 1, 5'd5, 1, 32'h80FF_FFFF, 0);
        run_op("lbu",     1, 0, 2'd0, 32'h0000_0203, 32'h0,         1, 1, 5'd5, 2, 32'h80FF_FFFF, 0);
        run_op("sh",      0, 1, 2'd1, 32'h0000_0302, 32'h0000_ABCD, 0, 0, 5'd0, 2, 32'h0,         0);
        run_op("lw_mis",  1, 0, 2'd2, 32'h0000_0101, 32'h0,         0, 1, 5'd6, 1, 32'h0,         0);
        run_op("lh_neg",  1, 0, 2'd1, 32'h0000_0402, 32'h0,         0, 1, 5'd7, 1, 32'h9234_5678, 0);
        run_op("lw_hold", 1, 0, 2'd2, 32'h0000_0200, 32'h0,         0, 1, 5'd8, 2, 32'hCAFE_F00D, 2);
        run_op("rdwr",    1, 1, 2'd0, 32'h0000_0401, 32'h0000_0055, 0, 1, 5'd9, 1, 32'h0,         0);
        run_op("mask11",  1, 0, 2'd3, 32'h0000_0604, 32'h0,         0, 1, 5'd1, 1, 32'h1357_9BDF, 0);

        // Reset while a load is outstanding.
        @(posedge clk); #1;
        mrd = 1'b1; mwr = 1'b0; mask = 2'd2; alu = 32'h0000_0500; wb_in = 1'b1; wa_in = 5'd2;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy:req_pre", 32'(req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy:req_async", 32'(req), 32'd0);
        check("rst_busy:stall",     32'(stall_out), 32'd1);
        check("rst_busy:wbdata",    wb_data, 32'h0000_0500);
        @(posedge clk); #1;
        mrd = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF; rst_n = 1'b1;
        @(posedge clk); #2;
        check("late_ack:req",   32'(req), 32'd0);
        check("late_ack:stall", 32'(stall_out), 32'd0);
        ack = 1'b0;
        run_op("lw_after_rst", 1, 0, 2'd2, 32'h0000_0500, 32'h0, 0, 1, 5'd2, 2, 32'h0BAD_F00D, 0);

        for (int i = 0; i < 150; i++) begin
            int unsigned sel = $urandom_range(0, 9);
            bit          r   = (sel >= 3 && sel <= 5) || sel == 9;
            bit          w   = sel >= 6;
            logic [31:0] a   = $urandom;
            logic [1:0]  m   = 2'($urandom_range(0, 3));
            bit          wbe = w ? (sel == 9) : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            if (m == 2'd1 && $urandom_range(0, 1) != 0) a[0] = 1'b0;
            run_op("rand", r, w, m, a, $urandom, 1'($urandom_range(0, 1)), wbe,
                   5'($urandom_range(0, 31)), int'($urandom_range(1, 4)), $urandom,
                   int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
